alu_uart_master: RTL
====================

ALU_UART_MASTER -- requirements
Module: alu_uart_master

Interface
REQ-001 SHALL have parameter PASSWORD, default 32'h31_32_33_34, unlock byte sequence sent MSB byte first.
REQ-002 SHALL have parameter PASS_LEN, default 4, number of password bytes sent (1..4, taken from the low-order end of PASSWORD, highest selected byte first).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, response wait limit in clk cycles.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  host command request.
REQ-007 cmd_ready  output  1  block idle, accepts command.
REQ-008 cmd_a  input  8  operand A.
REQ-009 cmd_b  input  8  operand B.
REQ-010 cmd_op  input  4  ALU select code.
REQ-011 tx_data  output  8  byte to UART transmitter.
REQ-012 tx_start  output  1  one-cycle transmit request pulse.
REQ-013 tx_busy  input  1  UART transmitter busy.
REQ-014 rx_data  input  8  byte from UART receiver.
REQ-015 rx_valid  input  1  one-cycle received-byte strobe.
REQ-016 res_valid  output  1  one-cycle result strobe.
REQ-017 res_data  output  8  ALU result byte, held until next res_valid.
REQ-018 res_timeout  output  1  qualifies res_valid: response not received.
REQ-019 authed  output  1  password already sent since reset/last timeout.

Function
REQ-020 States SHALL be IDLE, SEND_PASS, SEND_A, SEND_B, SEND_OP, WAIT_RES.
REQ-021 cmd_ready SHALL be 1 only in IDLE; cmd_valid&cmd_ready latches cmd_a/cmd_b/cmd_op same edge; cmd_valid outside IDLE ignored.
REQ-022 On accept: authed=0 -> SEND_PASS (byte index 0); authed=1 -> SEND_A.
REQ-023 Each byte send: ISSUE phase drives tx_data and pulses tx_start for exactly one cycle when tx_busy=0; ACK phase waits for tx_busy=1; DRAIN phase waits for tx_busy=0, then advances.
REQ-024 SEND_PASS SHALL send PASS_LEN bytes in order, then set authed=1 and go SEND_A.
REQ-025 SEND_A sends cmd_a, SEND_B sends cmd_b, SEND_OP sends {4'h0, cmd_op}, then WAIT_RES.
REQ-026 tx_data SHALL hold its value from ISSUE until the next ISSUE.
REQ-027 In WAIT_RES, rx_valid=1 SHALL load res_data=rx_data, pulse res_valid with res_timeout=0 next cycle, return to IDLE.
REQ-028 rx_valid in any state other than WAIT_RES SHALL be discarded with no output change.
REQ-029 rx_valid on the same edge as timeout expiry: received byte wins, no timeout reported.
REQ-030 Timeout counter SHALL clear on WAIT_RES entry and saturate at TIMEOUT_CYCLES-1; counter held at 0 outside WAIT_RES.
REQ-031 At most one tx_start pulse per byte; no tx_start while tx_busy=1.

Reset
REQ-032 Reset SHALL force IDLE, cmd_ready=1 after release, tx_start=0, tx_data=0, res_valid=0, res_data=0, res_timeout=0, authed=0, byte index and timeout counter 0.
REQ-033 Reset mid-transfer SHALL abandon the command without any res_valid; the next command resends the password.

Configuration
REQ-034 Macro ALU_UART_MASTER_TIMEOUT_EN defined: timeout counter present; reaching TIMEOUT_CYCLES in WAIT_RES pulses res_valid with res_timeout=1, res_data=0, clears authed, returns to IDLE.
REQ-035 Macro undefined: no counter; WAIT_RES waits indefinitely; res_timeout tied 0; authed cleared only by reset.

Verification
REQ-036 Reset, cmd a=8'h05 b=8'h03 op=4'h0, tx model busy 10 cycles/byte -> tx bytes 31,32,33,34,05,03,00; reply 8'h08 -> res_valid 1 cycle, res_data=8'h08, authed=1.
REQ-037 Second cmd a=8'hF0 b=8'h0F op=4'h2 -> tx bytes F0,0F,02 only (no password); reply 8'hFF -> res_data=8'hFF.
REQ-038 tx_busy held high 50 cycles before first ISSUE -> no tx_start until tx_busy=0; exactly one pulse per byte.
REQ-039 TIMEOUT_EN, TIMEOUT_CYCLES=100, no reply -> res_valid with res_timeout=1, res_data=0 exactly 100 cycles after WAIT_RES entry; authed=0; next cmd resends 4 password bytes.
REQ-040 Stray rx_valid with 8'hAA during SEND_B, and cmd_valid pulsed during WAIT_RES -> both ignored; later reply 8'h11 -> res_data=8'h11.
REQ-041 Reset asserted during SEND_A -> tx_start=0, cmd_ready=1 after release, no res_valid, authed=0.

Source files
------------

// File: rtl/alu_uart_master.sv
// Host-side master for a UART-attached ALU: unlocks with a password once, then sends A, B, op
// and returns the reply byte. Optional response timeout under `ALU_UART_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps

module alu_uart_master #(
  parameter logic [31:0] PASSWORD       = 32'h31_32_33_34,
  parameter int          PASS_LEN       = 4,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_op,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_timeout,
  output logic       authed
);

  typedef enum logic [2:0] {IDLE, SEND_PASS, SEND_A, SEND_B, SEND_OP, WAIT_RES} state_t;
  typedef enum logic [1:0] {ISSUE, ACK, DRAIN} phase_t;

  localparam logic [1:0] LAST_IDX = 2'(PASS_LEN - 1);

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] op_q, op_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
  logic       authed_q, authed_d;
  logic [1:0] pass_sel;
  logic [7:0] pass_byte;
  logic [7:0] cur_byte;

`ifdef ALU_UART_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_timeout_q, res_timeout_d;
  assign res_timeout = res_timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign res_timeout    = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign authed    = authed_q;

  // Index 0 picks the highest selected password byte.
  assign pass_sel = LAST_IDX - byte_idx_q;

  always_comb begin
    pass_byte = PASSWORD[31:24];
    case (pass_sel)
      2'd0:    pass_byte = PASSWORD[7:0];
      2'd1:    pass_byte = PASSWORD[15:8];
      2'd2:    pass_byte = PASSWORD[23:16];
      default: pass_byte = PASSWORD[31:24];
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      SEND_PASS: cur_byte = pass_byte;
      SEND_A:    cur_byte = a_q;
      SEND_B:    cur_byte = b_q;
      SEND_OP:   cur_byte = {4'h0, op_q};
      default:   cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    byte_idx_d  = byte_idx_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    authed_d    = authed_q;
`ifdef ALU_UART_MASTER_TIMEOUT_EN
    cnt_d         = '0;
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d        = cmd_a;
          b_d        = cmd_b;
          op_d       = cmd_op;
          byte_idx_d = 2'd0;
          phase_d    = ISSUE;
          state_d    = authed_q ? SEND_A : SEND_PASS;
        end
      end
      SEND_PASS, SEND_A, SEND_B, SEND_OP: begin
        case (phase_q)
          ISSUE: begin
            if (!tx_busy) begin
              tx_start_d = 1'b1;
              tx_data_d  = cur_byte;
              phase_d    = ACK;
            end
          end
          ACK: begin
            if (tx_busy) phase_d = DRAIN;
          end
          DRAIN: begin
            if (!tx_busy) begin
              phase_d = ISSUE;
              case (state_q)
                SEND_PASS: begin
                  if (byte_idx_q == LAST_IDX) begin
                    byte_idx_d = 2'd0;
                    authed_d   = 1'b1;
                    state_d    = SEND_A;
                  end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                  end
                end
                SEND_A:  state_d = SEND_B;
                SEND_B:  state_d = SEND_OP;
                default: state_d = WAIT_RES;
              endcase
            end
          end
          default: phase_d = ISSUE;
        endcase
      end
      WAIT_RES: begin
        // A reply arriving on the expiry edge takes priority over the timeout.
        if (rx_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = rx_data;
          state_d     = IDLE;
`ifdef ALU_UART_MASTER_TIMEOUT_EN
          res_timeout_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d         = cnt_q;
          res_valid_d   = 1'b1;
          res_data_d    = 8'h00;
          res_timeout_d = 1'b1;
          authed_d      = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= ISSUE;
      byte_idx_q  <= 2'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      op_q        <= 4'h0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      authed_q    <= 1'b0;
`ifdef ALU_UART_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      byte_idx_q  <= byte_idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      authed_q    <= authed_d;
`ifdef ALU_UART_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

endmodule
